// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall / flush / exception sequencer for a 5-stage MIPS pipeline.
//
// Produces the write-enable and flush controls for the PC, F/D, D/E, E/M and
// M/W pipeline registers. It tracks how long the multiply/divide unit stays
// busy, holds an eret in D while an older mtc0-to-EPC is still in flight, and
// turns a pending CP0 exception into a one-cycle request to every stage.
//
// Parameters:
//   MULT_CYC  busy cycles loaded for mult/multu
//   DIV_CYC   busy cycles loaded for div/divu
//   EXC_VEC   exception handler entry PC
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   d_hazard, d_is_md, d_eret  decode-stage status
//   e_md_start, e_md_div       MDU start in E (div=1 / mult=0)
//   e_mtc0_epc, m_mtc0_epc     mtc0-to-EPC in E / M
//   int_req                    CP0 exception pending for the M instruction
//   *_wren, fd_flush, de_flush pipeline register controls
//   req, exc_pc                exception request and handler PC
//   md_busy                    MDU occupied
//   stall_cnt                  stall cycle counter (only when PIPE_CTRL_PERF_EN)
//
// Build option: define PIPE_CTRL_PERF_EN to add the stall_cnt output.
// Every output reads 0 while reset is held low.

module pipe_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_hazard,
  input  logic        d_is_md,
  input  logic        d_eret,
  input  logic        e_md_start,
  input  logic        e_md_div,
  input  logic        e_mtc0_epc,
  input  logic        m_mtc0_epc,
  input  logic        int_req,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        de_wren,
  output logic        em_wren,
  output logic        mw_wren,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        req,
  output logic [31:0] exc_pc,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        md_busy
);

  typedef enum logic {ST_RUN, ST_EXC} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_md_cnt;
  logic       w_req;
  logic       w_md_busy;
  logic       w_stall;
  logic       w_eret_go;

  // Exception FSM. EXC exists only to force req low for one cycle, so a held
  // int_req yields a request on alternate cycles.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req = int_req;
        if (int_req) w_state_nxt = ST_EXC;
      end
      ST_EXC:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // MDU occupancy. A start that coincides with req belongs to an instruction
  // being cancelled and is not loaded; a count already running keeps going.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_md_cnt <= '0;
    else if (e_md_start && !w_req) r_md_cnt <= e_md_div ? 6'(DIV_CYC) : 6'(MULT_CYC);
    else if (r_md_cnt != '0)      r_md_cnt <= r_md_cnt - 6'd1;
  end

  assign w_md_busy = (r_md_cnt != '0) | (e_md_start & ~w_req);
  assign w_stall   = d_hazard | (d_is_md & w_md_busy) | (d_eret & (e_mtc0_epc | m_mtc0_epc));
  assign w_eret_go = d_eret & ~w_stall;

  // Priority req > stall > eret > normal. On req every register is enabled
  // because each stage clears itself on req and the PC loads exc_pc.
  always_comb begin
    pc_wren  = 1'b0;
    fd_wren  = 1'b0;
    de_wren  = 1'b0;
    em_wren  = 1'b0;
    mw_wren  = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    req      = 1'b0;
    exc_pc   = '0;
    md_busy  = 1'b0;
    if (reset) begin
      md_busy = w_md_busy;
      de_wren = 1'b1;
      em_wren = 1'b1;
      mw_wren = 1'b1;
      if (w_req) begin
        req     = 1'b1;
        exc_pc  = EXC_VEC;
        pc_wren = 1'b1;
        fd_wren = 1'b1;
      end else if (w_stall) begin
        de_flush = 1'b1;
      end else begin
        pc_wren  = 1'b1;
        fd_wren  = 1'b1;
        fd_flush = w_eret_go;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  // Counts cycles the front end is actually held (a stall overridden by req
  // does not count). Wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_stall_cnt <= '0;
    else if (w_stall && !w_req) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a table of single-cycle input vectors
// with hand-computed outputs, plus directed multi-cycle sequences.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        d_hazard = 1'b0, d_is_md = 1'b0, d_eret = 1'b0;
  logic        e_md_start = 1'b0, e_md_div = 1'b0;
  logic        e_mtc0_epc = 1'b0, m_mtc0_epc = 1'b0, int_req = 1'b0;
  logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
  logic        fd_flush, de_flush, req, md_busy;
  logic [31:0] exc_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_hazard   (d_hazard),
    .d_is_md    (d_is_md),
    .d_eret     (d_eret),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .e_mtc0_epc (e_mtc0_epc),
    .m_mtc0_epc (m_mtc0_epc),
    .int_req    (int_req),
    .pc_wren    (pc_wren),
    .fd_wren    (fd_wren),
    .de_wren    (de_wren),
    .em_wren    (em_wren),
    .mw_wren    (mw_wren),
    .fd_flush   (fd_flush),
    .de_flush   (de_flush),
    .req        (req),
    .exc_pc     (exc_pc),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt  (stall_cnt),
`endif
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs: {d_hazard, d_is_md, d_eret, e_md_start, e_md_div, e_mtc0_epc, m_mtc0_epc, int_req}
  // Outputs: {pc, fd, de, em, mw wren, fd_flush, de_flush, req, md_busy}
  typedef struct {
    string    name;
    logic [7:0] in;
    logic [8:0] out;
  } vec_t;

  localparam logic [8:0] O_NORM  = 9'b11111_0_0_0_0;
  localparam logic [8:0] O_STALL = 9'b00111_0_1_0_0;
  localparam logic [8:0] O_REQ   = 9'b11111_0_0_1_0;
  localparam logic [8:0] O_ERET  = 9'b11111_1_0_0_0;

  vec_t vecs[14];

  function automatic logic [8:0] outs();
    return {pc_wren, fd_wren, de_wren, em_wren, mw_wren, fd_flush, de_flush, req, md_busy};
  endfunction

  task automatic set_in(input logic [7:0] v);
    {d_hazard, d_is_md, d_eret, e_md_start, e_md_div, e_mtc0_epc, m_mtc0_epc, int_req} = v;
  endtask

  // Advance to just after the next rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"idle",            8'b0000_0000, O_NORM};
    vecs[1]  = '{"hazard",          8'b1000_0000, O_STALL};
    vecs[2]  = '{"is_md_not_busy",  8'b0100_0000, O_NORM};
    vecs[3]  = '{"eret_alone",      8'b0010_0000, O_ERET};
    vecs[4]  = '{"eret_e_epc",      8'b0010_0100, O_STALL};
    vecs[5]  = '{"eret_m_epc",      8'b0010_0010, O_STALL};
    vecs[6]  = '{"eret_hazard",     8'b1010_0000, O_STALL};
    vecs[7]  = '{"int_req",         8'b0000_0001, O_REQ};
    vecs[8]  = '{"int_over_stall",  8'b1000_0001, O_REQ};
    vecs[9]  = '{"int_over_eret",   8'b0010_0001, O_REQ};
    vecs[10] = '{"md_start_only",   8'b0001_0000, 9'b11111_0_0_0_1};
    vecs[11] = '{"md_start_is_md",  8'b0101_0000, 9'b00111_0_1_0_1};
    vecs[12] = '{"md_start_req",    8'b0101_1001, O_REQ};
    vecs[13] = '{"epc_no_eret",     8'b0000_0110, O_NORM};

    // Reset: outputs forced low even with active inputs.
    set_in(8'b1001_0001);
    repeat (3) begin
      sample();
      check("reset_outs", {23'd0, outs()}, 32'd0);
    end
    check("reset_exc_pc", exc_pc, 32'd0);
    tick();
    set_in(8'd0);
    reset = 1'b1;
    sample();
    check("reset_release", {23'd0, outs()}, {23'd0, O_NORM});
    check("release_exc_pc", exc_pc, 32'd0);

    // Table vectors, each from RUN with an idle MDU; idle drain afterwards.
    for (int i = 0; i < 14; i++) begin
      tick();
      set_in(vecs[i].in);
      sample();
      check(vecs[i].name, {23'd0, outs()}, {23'd0, vecs[i].out});
      check({vecs[i].name, "_exc_pc"}, exc_pc, vecs[i].out[1] ? EXC_VEC : 32'd0);
      tick();
      set_in(8'd0);
      repeat (12) tick();
    end

    // Mult occupancy: busy on the start cycle plus 5 countdown cycles.
    tick();
    set_in(8'b0101_0000);
    for (int c = 0; c < 6; c++) begin
      sample();
      check($sformatf("mult_busy_c%0d", c), {29'd0, md_busy, fd_wren, de_flush}, 32'b101);
      tick();
      set_in(8'b0100_0000);
    end
    sample();
    check("mult_release", {29'd0, md_busy, fd_wren, de_flush}, 32'b010);
    tick();
    set_in(8'd0);
    repeat (3) tick();

    // Div coinciding with req: no load.
    set_in(8'b0001_1001);
    sample();
    check("div_req_req", {31'd0, req}, 32'd1);
    check("div_req_exc_pc", exc_pc, EXC_VEC);
    check("div_req_busy", {31'd0, md_busy}, 32'd0);
    tick();
    set_in(8'd0);
    sample();
    check("div_req_busy_next", {31'd0, md_busy}, 32'd0);
    check("div_req_guard", {31'd0, req}, 32'd0);
    tick();
    sample();
    check("div_req_busy_next2", {31'd0, md_busy}, 32'd0);
    tick();

    // ERET hazard sequence.
    set_in(8'b0010_0100);
    sample();
    check("eret_seq_stall1", {23'd0, outs()}, {23'd0, O_STALL});
    tick();
    set_in(8'b0010_0010);
    sample();
    check("eret_seq_stall2", {23'd0, outs()}, {23'd0, O_STALL});
    tick();
    set_in(8'b0010_0000);
    sample();
    check("eret_seq_flush", {23'd0, outs()}, {23'd0, O_ERET});
    tick();
    set_in(8'd0);
    sample();
    check("eret_seq_after", {31'd0, fd_flush}, 32'd0);
    tick();

    // Held interrupt: req alternates 1,0,1,0 and exc_pc follows it.
    set_in(8'b0000_0001);
    for (int c = 0; c < 4; c++) begin
      sample();
      check($sformatf("held_int_req_c%0d", c), {31'd0, req}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("held_int_pc_c%0d", c), exc_pc, (c % 2 == 0) ? EXC_VEC : 32'd0);
      tick();
    end
    set_in(8'd0);
    repeat (2) tick();

`ifdef PIPE_CTRL_PERF_EN
    // Stall counter: 7 hazard cycles, the 4th overridden by req -> 6.
    reset = 1'b0;
    sample();
    check("perf_reset", stall_cnt, 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      set_in((c == 3) ? 8'b1000_0001 : 8'b1000_0000);
      tick();
    end
    set_in(8'd0);
    sample();
    check("perf_stall_cnt", stall_cnt, 32'd6);
    tick();
    sample();
    check("perf_stall_hold", stall_cnt, 32'd6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/exception sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable, flush and exception-request inputs of the PC, F/D, D/E, E/M and M/W pipeline registers.
- Tracks multi-cycle MDU occupancy and detects ERET/EPC hazards.
- Generates a single-cycle exception request toward all stage registers and CP0.

Parameters:
- MULT_CYC, 5, busy cycles loaded for mult/multu.
- DIV_CYC, 10, busy cycles loaded for div/divu.
- EXC_VEC, 32'h0000_4180, exception handler entry PC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_hazard  in  1  data-hazard stall request from the D-stage Tuse/Tnew comparator.
- d_is_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- d_eret  in  1  D instruction is eret.
- e_md_start  in  1  E instruction is mult/multu/div/divu.
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- e_mtc0_epc  in  1  E instruction is mtc0 to EPC.
- m_mtc0_epc  in  1  M instruction is mtc0 to EPC.
- int_req  in  1  exception/interrupt pending from CP0 for the M instruction.
- pc_wren, fd_wren, de_wren, em_wren, mw_wren  out  1 each  register write enables.
- fd_flush, de_flush  out  1 each  synchronous clear (bubble insert).
- req  out  1  exception request, broadcast to all stage registers.
- exc_pc  out  32  EXC_VEC while req=1, else 0.
- md_busy  out  1  MDU occupied.

Behaviour:
- Reset (reset=0, async):
  - Clears the MDU counter to 0 and sets the FSM to RUN.
  - While reset is low: all outputs 0 (wren, flush, req, md_busy = 0; exc_pc = 0).
- MDU counter (6 bits):
  - On a clock edge with e_md_start=1 and req=0, load DIV_CYC if e_md_div=1, else MULT_CYC.
  - Otherwise decrement when nonzero and hold at 0.
  - md_busy = (cnt != 0) | (e_md_start & ~req), combinational.
  - If req=1 on a cycle with e_md_start=1, the counter is not loaded (the younger instruction is cancelled).
  - A count already in progress continues through req; it is not cancelled.
- Exception FSM:
  - States: RUN and EXC.
  - RUN: req = int_req. If int_req=1, go to EXC.
  - EXC: req = 0 unconditionally (single-cycle pulse guard), then go to RUN next cycle.
  - A held int_req therefore produces req on alternate cycles only.
- stall = d_hazard | (d_is_md & md_busy) | (d_eret & (e_mtc0_epc | m_mtc0_epc)).
- Output priority: req > stall > eret > normal.
  - req=1: pc_wren=1 (PC loads exc_pc); all other wren=1 (registers clear themselves on req); fd_flush=0; de_flush=0.
  - stall (req=0): pc_wren=0, fd_wren=0, de_flush=1, de_wren=1, em_wren=1, mw_wren=1, fd_flush=0.
  - eret with no stall: all wren=1, fd_flush=1 (kills the delay-slot fetch), de_flush=0.
  - Normal: all wren=1, both flushes 0.
- Latency: all outputs are combinational from inputs plus registered state; no added pipeline latency.
- Simultaneous events:
  - stall and int_req in the same cycle: req wins; stall is ignored that cycle.
  - d_eret and d_hazard: stall; fd_flush=0 until the stall clears.
- Counter wrap: impossible. Load values are ≤ 63 and the counter never decrements below 0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - Adds output stall_cnt [31:0]: counts cycles with stall=1 & req=0.
  - Wraps modulo 2^32.
  - Async cleared to 0 by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release: reset low for 3 cycles, then high, no inputs → all wren=1, flushes 0, req=0, md_busy=0.
- Mult occupancy: e_md_start=1, e_md_div=0 for 1 cycle, then d_is_md=1 held:
  - md_busy=1 for 6 cycles (start cycle + 5 countdown).
  - fd_wren=0 and de_flush=1 throughout.
  - Released on the 7th cycle.
- Div vs req: e_md_start=1, e_md_div=1 with int_req=1 in the same cycle → req=1, exc_pc=32'h0000_4180, counter stays 0, md_busy=0 the next cycle.
- ERET hazard:
  - d_eret=1, e_mtc0_epc=1 → 1 cycle stall.
  - Next cycle m_mtc0_epc=1 → 1 more stall.
  - Then fd_flush=1 for exactly 1 cycle.
- Held interrupt: int_req=1 for 4 cycles → req pattern 1,0,1,0; exc_pc tracks req.
- PERF (macro on): d_hazard=1 for 7 cycles with int_req=1 on the 4th cycle → stall_cnt=6.
